simple_pipe_inst_issuer: RTL and testbench
==========================================

Name: simple_pipe_inst_issuer

Overview:
Transmit-side companion to the simplePipe instruction consumer. It accepts decoded instruction requests (op, rs1, rs2, rd) over a valid/ready handshake and buffers them in a small FIFO. It encodes each request into the 8-bit simplePipe instruction word and drives it to the pipe together with a start strobe. A destination scoreboard holds back read-after-write dependent instructions until the producer's result is architecturally visible.

Parameters:
DEPTH, 4, request FIFO entries; power of two, minimum 2.
PIPE_LAT, 3, cycles from issue until rd is written; minimum 2.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-low: state clears on a clk edge where rst==0.
req_valid  input  1  request present.
req_ready  output  1  FIFO can accept; combinational, equals !full.
req_op  input  2  opcode: 00 NOP, 01 ADD, 10/11 other ALU ops.
req_rs1  input  2  source register 1.
req_rs2  input  2  source register 2.
req_rd  input  2  destination register.
flush  input  1  drop all queued, unissued requests.
inst  output  8  encoded instruction {op[7:6], rs1[5:4], rs2[3:2], rd[1:0]}; registered.
__START__  output  1  issue strobe, one cycle per issued instruction; registered.
busy  output  1  FIFO non-empty or any scoreboard entry valid.
issued_cnt  output  8  count of issued instructions, saturating at 255.

Behaviour:
- Reset (rst==0 at an edge):
  - FIFO empties; all scoreboard entries become invalid.
  - inst=8'h00, __START__=0, issued_cnt=0.
  - After reset, req_ready=1 and busy=0.
  - Reset overrides every other input in that cycle, including mid-stall and a full FIFO.
- Enqueue:
  - A request is accepted when req_valid && req_ready at an edge.
  - When the FIFO is full, req_ready=0 even if a dequeue happens in the same cycle. There is no same-cycle full pass-through.
- Encoding: inst is the bit-concatenation above. A NOP encodes its rs/rd fields as given.
- Scoreboard:
  - PIPE_LAT entries sb[0..PIPE_LAT-1], each holding {v, rd}.
  - Every edge: sb[i] <= sb[i-1] for i>0, and sb[0] <= {issuing && op!=00, head.rd}.
- Hazard:
  - Raised when the FIFO head has op!=00 and head.rs1 or head.rs2 equals sb[i].rd, with sb[i].v set, for any i in 0..PIPE_LAT-2.
  - NOP never causes or suffers a hazard.
- Issue:
  - At an edge, if the FIFO is non-empty, there is no hazard and flush==0, the head is popped. inst <= encoding and __START__ <= 1.
  - Otherwise __START__ <= 0 and inst holds its previous value.
- Latency and spacing:
  - A request accepted at edge E0 into an empty, hazard-free FIFO produces __START__=1 after edge E0+1.
  - A dependent instruction issues no sooner than PIPE_LAT edges after its producer, i.e. PIPE_LAT-1 bubble cycles.
  - Independent instructions issue back-to-back, one per cycle.
- Flush:
  - The FIFO empties at the edge, and no issue occurs that edge.
  - The scoreboard keeps shifting (in-flight ops remain tracked).
  - A request presented with flush is discarded.
- issued_cnt increments on each issue, including NOP issues. It holds at 255.
- FIFO pointers wrap modulo DEPTH.

Optional Feature:
ISSUER_STALL_CNT_EN:
- Defined: adds output stall_cnt[7:0]. It increments, saturating at 255, on each edge where the FIFO is non-empty, hazard==1 and flush==0. It clears on reset.
- Undefined: the port and its logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 2 edges, then release -> inst=00, __START__=0, req_ready=1, busy=0, issued_cnt=0.
- Encoding: ADD rs1=2, rs2=3, rd=1 into an empty FIFO -> one edge later inst=8'h6D with a single-cycle __START__, issued_cnt=1.
- RAW hazard, PIPE_LAT=3:
  - Send ADD rd=1 then ADD rs1=1, rs2=0, rd=2 back-to-back.
  - Required: exactly 2 bubble cycles between the __START__ pulses; the second inst=8'h52.
  - With ISSUER_STALL_CNT_EN defined, stall_cnt=2.
- Full FIFO:
  - Stall the head on a hazard and push until req_ready=0 (4 accepted).
  - A 5th req_valid is not accepted.
  - After the hazard clears, the 4 instructions issue in order on 4 consecutive cycles.
- Flush: 3 queued requests, then pulse flush -> no __START__ follows; busy drops once the scoreboard drains; issued_cnt is unchanged.
- Saturation and mid-operation reset:
  - Issue 260 NOPs -> issued_cnt=255.
  - Then assert rst=0 while the FIFO is non-empty -> all state cleared the next edge.

Source files
------------

// File: rtl/simple_pipe_inst_issuer.sv
// Instruction issuer for the simplePipe consumer: request FIFO, 8-bit encoder and RAW destination scoreboard.
// Optional stall counter output enabled by defining ISSUER_STALL_CNT_EN.
module simple_pipe_inst_issuer #(
    parameter int DEPTH    = 4,
    parameter int PIPE_LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [1:0] req_rs1,
    input  logic [1:0] req_rs2,
    input  logic [1:0] req_rd,
    input  logic       flush,
    output logic [7:0] inst,
    output logic       __START__,
    output logic       busy,
    output logic [7:0] issued_cnt
`ifdef ISSUER_STALL_CNT_EN
    ,
    output logic [7:0] stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [7:0]          fifo_mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic                full;
    logic                empty;
    logic                push;
    logic                issue;
    logic                hazard;
    logic [7:0]          head;
    logic [PIPE_LAT-1:0] sb_v;
    logic [1:0]          sb_rd [PIPE_LAT];

    assign full      = (count == DEPTH_W);
    assign empty     = (count == '0);
    assign req_ready = !full;
    assign head      = fifo_mem[rd_ptr];
    assign push      = req_valid && !full && !flush;
    assign issue     = !empty && !hazard && !flush;
    assign busy      = !empty || (|sb_v);

    // The oldest scoreboard slot is already architecturally visible, so it is excluded.
    always_comb begin
        hazard = 1'b0;
        if (!empty && head[7:6] != 2'b00) begin
            for (int i = 0; i < PIPE_LAT - 1; i++) begin
                if (sb_v[i] && (sb_rd[i] == head[5:4] || sb_rd[i] == head[3:2]))
                    hazard = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {req_op, req_rs1, req_rs2, req_rd};
        sb_rd[0] <= head[1:0];
        for (int i = 1; i < PIPE_LAT; i++)
            sb_rd[i] <= sb_rd[i-1];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            sb_v       <= '0;
            inst       <= 8'h00;
            __START__  <= 1'b0;
            issued_cnt <= 8'h00;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (issue)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + (AW + 1)'(push) - (AW + 1)'(issue);
            end
            __START__ <= issue;
            if (issue)
                inst <= head;
            if (issue && issued_cnt != 8'hFF)
                issued_cnt <= issued_cnt + 8'd1;
            // NOPs write nothing, so they never occupy a valid scoreboard slot.
            sb_v <= {sb_v[PIPE_LAT-2:0], issue && (head[7:6] != 2'b00)};
        end
    end

`ifdef ISSUER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst)
            stall_cnt <= 8'h00;
        else if (!empty && hazard && !flush && stall_cnt != 8'hFF)
            stall_cnt <= stall_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_simple_pipe_inst_issuer.sv
// Directed bench for simple_pipe_inst_issuer: expected instruction words queued at enqueue, checked on each start strobe.
module tb_simple_pipe_inst_issuer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_op = 2'd0;
    logic [1:0] req_rs1 = 2'd0;
    logic [1:0] req_rs2 = 2'd0;
    logic [1:0] req_rd = 2'd0;
    logic       flush = 1'b0;
    logic       req_ready;
    logic [7:0] inst;
    logic       start;
    logic       busy;
    logic [7:0] issued_cnt;
`ifdef ISSUER_STALL_CNT_EN
    logic [7:0] stall_cnt;
`endif

    simple_pipe_inst_issuer #(.DEPTH(4), .PIPE_LAT(3)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_rs1(req_rs1),
        .req_rs2(req_rs2),
        .req_rd(req_rd),
        .flush(flush),
        .inst(inst),
        .__START__(start),
        .busy(busy),
        .issued_cnt(issued_cnt)
`ifdef ISSUER_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         n_pass = 0;
    int         n_total = 0;
    int         cyc = 0;
    int         exp_issued = 0;
    logic [7:0] exp_q[$];
    int         start_log[$];
    bit         acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (start === 1'b1) begin
            start_log.push_back(cyc);
            if (exp_q.size() == 0)
                check("start_without_request", 32'(start), 32'd0);
            else
                check("inst", 32'(inst), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] rs1, input logic [1:0] rs2,
                        input logic [1:0] rd, input bit expect_issue, output bit accepted);
        req_op = op; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
        req_valid = 1'b1;
        accepted = req_ready && !flush;
        if (accepted && expect_issue) begin
            exp_q.push_back({op, rs1, rs2, rd});
            if (exp_issued < 255) exp_issued++;
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_drain_timeout"}, 32'(n < 400), 32'd1);
    endtask

    initial begin
        // reset
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        check("rst_inst", 32'(inst), 32'h00);
        check("rst_start", 32'(start), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_issued", 32'(issued_cnt), 32'd0);

        // encoding and latency
        send(2'd1, 2'd2, 2'd3, 2'd1, 1'b1, acc);
        check("enc_start_e0", 32'(start), 32'd0);
        tick();
        check("enc_start_e1", 32'(start), 32'd1);
        check("enc_inst", 32'(inst), 32'h6D);
        check("enc_issued", 32'(issued_cnt), 32'd1);
        tick();
        check("enc_start_single", 32'(start), 32'd0);
        check("enc_inst_hold", 32'(inst), 32'h6D);
        drain("enc");

        // RAW hazard spacing
        start_log.delete();
        send(2'd1, 2'd0, 2'd0, 2'd1, 1'b1, acc);
        send(2'd1, 2'd1, 2'd0, 2'd2, 1'b1, acc);
        drain("raw");
        check("raw_starts", 32'(start_log.size()), 32'd2);
        if (start_log.size() == 2)
            check("raw_gap", 32'(start_log[1] - start_log[0]), 32'd3);
        check("raw_inst", 32'(inst), 32'h52);
        check("raw_issued", 32'(issued_cnt), 32'(exp_issued));
`ifdef ISSUER_STALL_CNT_EN
        check("raw_stall_cnt", 32'(stall_cnt), 32'd2);
`endif

        // full FIFO behind a chained hazard
        start_log.delete();
        send(2'd1, 2'd0, 2'd0, 2'd3, 1'b1, acc);
        send(2'd1, 2'd3, 2'd0, 2'd2, 1'b1, acc);
        send(2'd1, 2'd2, 2'd2, 2'd0, 1'b1, acc);
        send(2'd2, 2'd1, 2'd1, 2'd3, 1'b1, acc);
        send(2'd3, 2'd1, 2'd1, 2'd3, 1'b1, acc);
        send(2'd0, 2'd1, 2'd1, 2'd3, 1'b1, acc);
        check("full_last_accepted", 32'(acc), 32'd1);
        check("full_ready_low", 32'(req_ready), 32'd0);
        send(2'd2, 2'd0, 2'd0, 2'd0, 1'b1, acc);
        check("full_extra_rejected", 32'(acc), 32'd0);
        drain("full");
        check("full_starts", 32'(start_log.size()), 32'd6);
        if (start_log.size() == 6) begin
            check("full_dep_gap", 32'(start_log[2] - start_log[1]), 32'd3);
            check("full_burst", 32'(start_log[5] - start_log[2]), 32'd3);
        end

        // flush
        start_log.delete();
        send(2'd1, 2'd0, 2'd0, 2'd2, 1'b1, acc);
        send(2'd1, 2'd2, 2'd0, 2'd0, 1'b0, acc);
        send(2'd2, 2'd1, 2'd1, 2'd1, 1'b0, acc);
        send(2'd3, 2'd1, 2'd1, 2'd1, 1'b0, acc);
        check("flush_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        send(2'd1, 2'd3, 2'd3, 2'd3, 1'b0, acc);
        flush = 1'b0;
        repeat (6) tick();
        check("flush_starts", 32'(start_log.size()), 32'd1);
        check("flush_busy_after", 32'(busy), 32'd0);
        check("flush_issued", 32'(issued_cnt), 32'(exp_issued));

        // saturation with back-to-back NOPs
        start_log.delete();
        for (int i = 0; i < 260; i++) begin
            logic [7:0] f;
            f = 8'(i);
            send(2'd0, f[1:0], f[3:2], f[5:4], 1'b1, acc);
        end
        drain("sat");
        check("sat_issued", 32'(issued_cnt), 32'd255);
        check("sat_starts", 32'(start_log.size()), 32'd260);
        if (start_log.size() == 260)
            check("sat_back_to_back", 32'(start_log[259] - start_log[0]), 32'd259);

        // reset while requests are queued behind a hazard
        start_log.delete();
        send(2'd1, 2'd0, 2'd0, 2'd1, 1'b1, acc);
        send(2'd1, 2'd1, 2'd0, 2'd2, 1'b0, acc);
        send(2'd2, 2'd1, 2'd1, 2'd3, 1'b0, acc);
        check("mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        tick();
        check("mid_inst", 32'(inst), 32'h00);
        check("mid_start", 32'(start), 32'd0);
        check("mid_ready", 32'(req_ready), 32'd1);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_issued", 32'(issued_cnt), 32'd0);
        exp_issued = 0;
        rst = 1'b1;
        repeat (8) tick();
        check("mid_starts", 32'(start_log.size()), 32'd1);
        check("mid_issued_after", 32'(issued_cnt), 32'(exp_issued));
`ifdef ISSUER_STALL_CNT_EN
        check("mid_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
